// File: rtl/rf_nz_scheduler.sv
// Zero-skipping read sequencer: walks snapshotted nonzero flags and streams (index, data).
// Optional RF_NZ_SCHEDULER_COUNT_EN adds an nz_count output of accepted handshakes per scan.
module rf_nz_scheduler #(
    parameter int BIT_WIDTH  = 16,
    parameter int REG_DEPTH  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [REG_DEPTH-1:0]  nz_flags,
    output logic                  rf_read_en,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [BIT_WIDTH-1:0]  rf_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [BIT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef RF_NZ_SCHEDULER_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   nz_count
`endif
);

    generate
        if (ADDR_WIDTH != $clog2(REG_DEPTH)) begin : g_bad_width
            $error("ADDR_WIDTH must equal clog2(REG_DEPTH)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [REG_DEPTH-1:0] MASK_ONE = REG_DEPTH'(1);

    state_e                state_q, state_d;
    logic [REG_DEPTH-1:0]  mask_q, mask_d;
    logic [REG_DEPTH-1:0]  mask_rest;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  load;
    logic                  hs;

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [BIT_WIDTH-1:0]  data_q, data_d;
    logic                  last_q, last_d;

    // Priority search from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = REG_DEPTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit equals clearing bit idx.
    assign mask_rest = mask_q & (mask_q - MASK_ONE);

    assign hs   = valid_q & out_ready;
    assign load = (state_q == S_RUN) && (mask_q != '0)
                  && (!valid_q || out_ready);

    assign rf_read_en   = load;
    assign rf_read_addr = load ? idx : '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (nz_flags != '0) begin
                        state_d = S_RUN;
                        mask_d  = nz_flags;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (load) begin
                    mask_d = mask_rest;
                end
                if ((mask_q == '0) && (!valid_q || (hs && last_q))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            index_d = idx;
            data_d  = rf_read_data;
            last_d  = (mask_rest == '0);
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_index = index_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

`ifdef RF_NZ_SCHEDULER_COUNT_EN
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_IDLE) && start) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_count = cnt_q;
`endif

endmodule

// File: tb/tb_rf_nz_scheduler.sv
// Randomized self-checking bench for rf_nz_scheduler against a queue-based scan model.
module tb_rf_nz_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] nz_flags = '0;
    logic        rf_read_en;
    logic [5:0]  rf_read_addr;
    logic [15:0] rf_read_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_index;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef RF_NZ_SCHEDULER_COUNT_EN
    logic [6:0]  nz_count;
`endif

    logic [15:0] mem [64];
    int tests = 0;
    int fails = 0;

    assign rf_read_data = mem[rf_read_addr];

    always #5 clk = ~clk;

    rf_nz_scheduler #(
        .BIT_WIDTH(16),
        .REG_DEPTH(64),
        .ADDR_WIDTH(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .nz_flags(nz_flags),
        .rf_read_en(rf_read_en),
        .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
`ifdef RF_NZ_SCHEDULER_COUNT_EN
        ,
        .nz_count(nz_count)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if ({out_valid, busy, done, rf_read_en, out_last} !== 5'b0 ||
            out_index !== 6'd0 || out_data !== 16'd0 || rf_read_addr !== 6'd0) begin
            fails++;
            $display("FAIL reset_outputs got v%b b%b d%b en%b l%b i%0d d%h a%0d exp all 0",
                     out_valid, busy, done, rf_read_en, out_last,
                     out_index, out_data, rf_read_addr);
        end
`ifdef RF_NZ_SCHEDULER_COUNT_EN
        tests++;
        if (nz_count !== 7'd0) begin
            fails++;
            $display("FAIL reset_count got %0d exp 0", nz_count);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Caller must be at posedge+1 with the DUT in IDLE.
    task automatic run_scan(input logic [63:0] flags, input int stall,
                            input bit rnd, input bit repulse);
        int exp_q[$];
        int n, got, loaded, cyc, last_hs, stall_left;
        bit fin, prev_stall, exp_en;
        logic [5:0]  p_idx;
        logic [15:0] p_dat;
        logic        p_last;
        for (int i = 0; i < 64; i++) begin
            if (flags[i]) exp_q.push_back(i);
        end
        n = exp_q.size();
        got = 0; loaded = 0; cyc = 0; last_hs = -1;
        stall_left = stall; fin = 0; prev_stall = 0;
        p_idx = '0; p_dat = '0; p_last = 1'b0;
        start = 1'b1;
        nz_flags = flags;
        @(posedge clk);
        #1;
        start = 1'b0;
        nz_flags = {$urandom, $urandom};
        while (!fin) begin
            tests++;
            if (out_valid !== (loaded > got)) begin
                fails++;
                $display("FAIL valid_c%0d got %b exp %b", cyc, out_valid, loaded > got);
            end
            tests++;
            if (busy !== (n > 0 && done !== 1'b1)) begin
                fails++;
                $display("FAIL busy_c%0d got %b exp %b", cyc, busy, n > 0 && done !== 1'b1);
            end
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_index !== p_idx ||
                    out_data !== p_dat || out_last !== p_last) begin
                    fails++;
                    $display("FAIL stall_hold_c%0d got %b/%0d/%h/%b exp 1/%0d/%h/%b",
                             cyc, out_valid, out_index, out_data, out_last,
                             p_idx, p_dat, p_last);
                end
            end
            if (done === 1'b1) begin
                tests++;
                if (got !== n || (n == 0 ? cyc != 0 : cyc != last_hs + 1)) begin
                    fails++;
                    $display("FAIL done_timing got cyc%0d outs%0d exp cyc%0d outs%0d",
                             cyc, got, n == 0 ? 0 : last_hs + 1, n);
                end
`ifdef RF_NZ_SCHEDULER_COUNT_EN
                tests++;
                if (nz_count !== 7'(n)) begin
                    fails++;
                    $display("FAIL count_done got %0d exp %0d", nz_count, n);
                end
`endif
                fin = 1;
            end else begin
                if (out_valid === 1'b1 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                #1;
                exp_en = busy && (loaded < n) && (!(loaded > got) || out_ready);
                tests++;
                if (rf_read_en !== exp_en ||
                    (exp_en && rf_read_addr !== 6'(exp_q[loaded]))) begin
                    fails++;
                    $display("FAIL read_port_c%0d got en%b a%0d exp en%b a%0d", cyc,
                             rf_read_en, rf_read_addr, exp_en,
                             exp_en ? exp_q[loaded] : 0);
                end
                if (exp_en) loaded++;
                prev_stall = (out_valid === 1'b1) && !out_ready;
                p_idx = out_index; p_dat = out_data; p_last = out_last;
                if (out_valid === 1'b1 && out_ready) begin
                    tests++;
                    if (got >= n) begin
                        fails++;
                        $display("FAIL extra_output got idx%0d exp none", out_index);
                    end else if (out_index !== 6'(exp_q[got]) ||
                                 out_data !== mem[exp_q[got]] ||
                                 out_last !== (got == n - 1)) begin
                        fails++;
                        $display("FAIL output_%0d got %0d/%h/%b exp %0d/%h/%b", got,
                                 out_index, out_data, out_last, exp_q[got],
                                 mem[exp_q[got]], got == n - 1);
                    end
                    got++;
                    last_hs = cyc;
                end
                if (repulse && cyc == 2) begin
                    start = 1'b1;
                    nz_flags = ~flags;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (cyc > 400) begin
                    tests++;
                    fails++;
                    $display("FAIL timeout got no done exp done within 400 cycles");
                    fin = 1;
                end
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after got d%b b%b v%b exp 0 0 0", done, busy, out_valid);
        end
`ifdef RF_NZ_SCHEDULER_COUNT_EN
        tests++;
        if (nz_count !== 7'(n)) begin
            fails++;
            $display("FAIL count_idle got %0d exp %0d", nz_count, n);
        end
`endif
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 64; i++) mem[i] = 16'(i + 'h100);
        run_scan(64'h0000_0000_0000_0112, 0, 0, 0);
    endtask

    task automatic test_empty();
        run_scan(64'h0, 0, 0, 0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        run_scan(64'h8000_0000_0000_0001, 5, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_scan({64{1'b1}}, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        start = 1'b1;
        nz_flags = 64'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, busy, done, rf_read_en, out_last} !== 5'b0 ||
            out_index !== 6'd0 || out_data !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset got v%b b%b d%b en%b l%b i%0d d%h exp all 0",
                     out_valid, busy, done, rf_read_en, out_last, out_index, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_scan(64'h2, 0, 0, 0);
    endtask

    task automatic test_restart_ignored();
        run_scan(64'h0000_00F0_0000_0F00, 0, 0, 1);
        run_scan(64'h0000_0000_0001_0003, 2, 1, 1);
    endtask

    task automatic test_random();
        logic [63:0] f;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            f = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (k == 7) f = 64'h1 << $urandom_range(0, 63);
            run_scan(f, $urandom_range(0, 3), 1, k[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_sparse();
        test_empty();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_restart_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_nz_scheduler.md
Name: rf_nz_scheduler

Overview:
- Zero-skipping read sequencer for the activation register file.
- On `start`, snapshots the register file's per-entry nonzero flags.
- Walks the set flags in ascending index order, issuing one combinational register-file read per nonzero entry.
- Streams (index, data) pairs to the downstream MAC stage over a valid/ready handshake, so zero activations never consume compute cycles.

Parameters:
- BIT_WIDTH, 16, width of one register-file entry and of out_data
- REG_DEPTH, 64, number of register-file entries and width of nz_flags
- ADDR_WIDTH, 6, index width; must equal ceil(log2(REG_DEPTH))

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin one scan; ignored unless in IDLE
- nz_flags  input  REG_DEPTH  per-entry flag from the register file; 1 = entry nonzero
- rf_read_en  output  1  register-file read enable
- rf_read_addr  output  ADDR_WIDTH  register-file read address
- rf_read_data  input  BIT_WIDTH  register-file read data, same-cycle combinational
- out_valid  output  1  out_index/out_data/out_last valid
- out_ready  input  1  downstream accepts the current output
- out_index  output  ADDR_WIDTH  entry index of the current output
- out_data  output  BIT_WIDTH  entry value of the current output
- out_last  output  1  current output is the final nonzero entry of this scan
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of scan

Behaviour:
- Reset state: IDLE. All outputs 0; mask register 0; output register empty.
- States and transitions:
  - IDLE -> RUN: `start`=1 and `nz_flags`≠0. Mask <= nz_flags.
  - IDLE -> DONE: `start`=1 and `nz_flags`=0. No outputs are produced.
  - RUN -> DONE: mask=0 and the output register is empty, or is being emptied this cycle with out_valid & out_ready & out_last.
  - DONE -> IDLE unconditionally. `done`=1 only in DONE.
- Selection:
  - idx = lowest set bit of mask.
  - load = (state==RUN) & (mask≠0) & (!out_valid | out_ready).
- Read port:
  - rf_read_en = load.
  - rf_read_addr = idx when load, else 0. Combinational from state/mask/out_valid/out_ready.
- On load, at the next edge:
  - out_index <= idx; out_data <= rf_read_data; out_valid <= 1.
  - out_last <= (mask with bit idx cleared)==0.
  - Clear bit idx in mask.
- Output register:
  - Handshake without load: out_valid <= 0.
  - While out_valid=1 and out_ready=0: out_index, out_data, out_last hold stable.
- Throughput and latency:
  - One entry per cycle when out_ready is held high.
  - `start` sampled at edge t: first read issued in cycle t+1, out_valid=1 from cycle t+2.
- Snapshot semantics:
  - Changes on `nz_flags` after `start` do not alter the scan.
  - Data is whatever the register file returns at read time, including its write-forwarded value.
- Boundaries:
  - `start` in RUN or DONE: ignored.
  - All REG_DEPTH flags set: REG_DEPTH outputs, indices 0..REG_DEPTH-1, last on index REG_DEPTH-1.
  - Single flag: one output with out_last=1.
  - `rst` mid-scan: immediate return to IDLE, outputs cleared, pending data discarded.
- Width rule: out_data is passed unmodified, no arithmetic.

Optional Feature:
- Macro: RF_NZ_SCHEDULER_COUNT_EN.
- When defined:
  - Extra output `nz_count`, width ADDR_WIDTH+1.
  - Cleared to 0 on reset and on each accepted `start`.
  - Incremented on each out_valid & out_ready handshake.
  - Holds its final value through DONE and IDLE until the next `start`.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- REG_DEPTH=64, nz_flags=0x0000_0000_0000_0112 (bits 1, 4, 8), out_ready=1, RF entry i holds i+0x100:
  - three outputs on consecutive cycles: (1, 0x101, last=0), (4, 0x104, last=0), (8, 0x108, last=1).
  - done pulses one cycle after the last handshake.
  - nz_count=3 if enabled.
- nz_flags=0 with start:
  - no out_valid; done=1 in the cycle after start; busy stays 0.
- nz_flags=0x8000_0000_0000_0001, out_ready held 0 for 5 cycles, then 1:
  - out_valid=1 with index 0 held stable for 5 cycles; rf_read_en=0 while stalled.
  - Then index 0, then index 63 with last=1.
- nz_flags=all ones, out_ready=1:
  - 64 back-to-back outputs, indices 0..63 in order; only the final one has last=1.
  - done 1 cycle after index 63 is accepted.
- rst asserted 3 cycles into a scan of 0xFF:
  - all outputs 0 the same cycle; IDLE afterward.
  - A new start with 0x2 yields a single output, index 1, last=1.
- start re-pulsed during RUN with a different nz_flags value:
  - ignored; the original scan's index sequence is unchanged.
